// File: rtl/cpu_pkg.sv
// Shared definitions for the shift execution stage: datapath width,
// operation encodings and the sequencer state encoding.
package cpu_pkg;

    localparam int WIDTH = 24;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PASS1 = 2'b01,
        PASS2 = 2'b10,
        DONE  = 2'b11
    } shift_state_e;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 24-bit left-only barrel shifter. Any amount of 24 or more
// shifts every bit out, so the result is zero; the full amount is honoured.
module barrel_shifter
    import cpu_pkg::*;
(
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] shift,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] staged;

    // Log-depth shift over the low five amount bits, then clear on any upper bit.
    always_comb begin
        staged = data;
        for (int i = 0; i < 5; i++) begin
            if (shift[i]) begin
                staged = staged << (1 << i);
            end
        end
        result = (|shift[WIDTH-1:5]) ? '0 : staged;
    end

endmodule

// File: rtl/shift_unit.sv
// Sequential shift execution stage. Runs SLL/SRL/SRA in one pass and ROL in
// two passes through a single left-only barrel shifter, registering the
// result with carry and zero flags for writeback.
//
// Handshake: an operation transfers on a rising edge where start_valid and
// start_ready are both high; a result transfers on a rising edge where
// res_valid and res_ready are both high. valid never depends on ready, and
// result/carry/zero hold stable while res_valid is high and res_ready is low.
module shift_unit
    import cpu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] amount,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             busy
);

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    shift_state_e     state, state_nxt;
    shift_op_e        op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] amt_q;
    logic [4:0]       rol_n_q;
    logic [WIDTH-1:0] partial_q;

    logic [WIDTH-1:0] sh_in, sh_amt, sh_out;
    logic [WIDTH-1:0] right_out, sra_fill;
    logic [WIDTH-1:0] pass1_res, rol_res;
    logic             pass1_carry, rol_carry;
    logic [4:0]       n5;
    logic             amt_small;

    barrel_shifter u_shifter (
        .data   (sh_in),
        .shift  (sh_amt),
        .result (sh_out)
    );

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

    // Next-state logic for the IDLE -> PASS1 -> [PASS2] -> DONE sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_valid) state_nxt = PASS1;
            PASS1: state_nxt = (op_q == SH_ROL) ? PASS2 : DONE;
            PASS2: state_nxt = DONE;
            DONE:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand steering: right shifts go through the left shifter reversed;
    // the second ROL pass is the complementary right shift by 24-n.
    always_comb begin
        sh_in  = '0;
        sh_amt = '0;
        if (state == PASS1) begin
            case (op_q)
                SH_SLL: begin sh_in = data_q;          sh_amt = amt_q; end
                SH_ROL: begin sh_in = data_q;          sh_amt = {19'd0, rol_n_q}; end
                default: begin sh_in = bit_rev(data_q); sh_amt = amt_q; end
            endcase
        end else if (state == PASS2) begin
            sh_in  = bit_rev(data_q);
            sh_amt = {19'd0, 5'd24 - rol_n_q};
        end
    end

    // Results and flags for both passes.
    always_comb begin
        n5        = amt_q[4:0];
        amt_small = (amt_q <= 24'd24);
        right_out = bit_rev(sh_out);
        // Top-n sign fill: left-shifted ones, reversed, then inverted.
        sra_fill  = data_q[WIDTH-1] ? ~bit_rev({WIDTH{1'b1}} << amt_q) : '0;

        pass1_carry = 1'b0;
        case (op_q)
            SH_SLL: begin
                pass1_res = sh_out;
                if (amt_q != '0 && amt_small) pass1_carry = data_q[5'd24 - n5];
            end
            SH_SRL: begin
                pass1_res = right_out;
                if (amt_q != '0 && amt_small) pass1_carry = data_q[n5 - 5'd1];
            end
            SH_SRA: begin
                pass1_res = right_out | sra_fill;
                if (amt_q >= 24'd24)    pass1_carry = data_q[WIDTH-1];
                else if (amt_q != '0)   pass1_carry = data_q[n5 - 5'd1];
            end
            default: pass1_res = sh_out;
        endcase

        rol_res   = partial_q | right_out;
        rol_carry = (rol_n_q != 5'd0) ? rol_res[0] : 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Operand capture, partial and registered result/flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= SH_SLL;
            data_q    <= '0;
            amt_q     <= '0;
            rol_n_q   <= '0;
            partial_q <= '0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    op_q    <= shift_op_e'(op);
                    data_q  <= data;
                    amt_q   <= amount;
                    rol_n_q <= 5'(amount % 24'd24);
                end
                PASS1: begin
                    if (op_q == SH_ROL) begin
                        partial_q <= sh_out;
                    end else begin
                        result <= pass1_res;
                        carry  <= pass1_carry;
                        zero   <= (pass1_res == '0);
                    end
                end
                PASS2: begin
                    result <= rol_res;
                    carry  <= rol_carry;
                    zero   <= (rol_res == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Testbench for shift_unit: directed vector table, randomized operations
// against an arithmetic reference model, backpressure and mid-operation reset.
module tb_shift_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  op;
    logic [23:0] data;
    logic [23:0] amount;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] result;
    logic        carry;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op          (op),
        .data        (data),
        .amount      (amount),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] data;
        logic [23:0] amt;
        logic [23:0] exp_res;
        logic        exp_carry;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic meaning of each operation.
    function automatic void ref_model(input logic [1:0] o, input logic [23:0] d,
                                      input logic [23:0] a,
                                      output logic [23:0] r, output logic c);
        longint unsigned dv = longint'(d);
        longint unsigned n  = longint'(a);
        longint unsigned full;
        longint          sx;
        longint unsigned k;
        r = d;
        c = 1'b0;
        case (o)
            2'b00: if (n != 0) begin
                if (n <= 24) begin
                    full = dv << n;
                    r = full[23:0];
                    c = full[24];
                end else begin
                    r = '0;
                end
            end
            2'b01: if (n != 0) begin
                if (n <= 24) begin
                    full = dv >> n;
                    r = full[23:0];
                    c = dv[n-1];
                end else begin
                    r = '0;
                end
            end
            2'b10: if (n != 0) begin
                sx = d[23] ? longint'(dv) - 64'sh1000000 : longint'(dv);
                sx = sx >>> ((n >= 24) ? 24 : n);
                r = sx[23:0];
                c = (n >= 24) ? d[23] : dv[n-1];
            end
            default: begin
                k = n % 24;
                if (k != 0) begin
                    full = (dv << k) | (dv >> (24 - k));
                    r = full[23:0];
                    c = r[0];
                end
            end
        endcase
    endfunction

    // Offer one operation, return edges from accept to res_valid (bounded).
    task automatic issue(input logic [1:0] o, input logic [23:0] d,
                         input logic [23:0] a, output int lat);
        @(negedge clk);
        check("start_ready_before_issue", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        op = o;
        data = d;
        amount = a;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start_valid = 1'b0;
        op = 2'($urandom);
        data = 24'($urandom);
        amount = 24'($urandom);
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!res_valid) begin
            check("res_valid_timeout", 32'(res_valid), 32'd1);
        end
    endtask

    // Take the result: one edge with res_ready high, unit should be idle after.
    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("idle_after_take", {30'd0, start_ready, res_valid}, 32'b10);
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        logic [23:0] er;
        logic ec;

        reset = 1'b1;
        start_valid = 1'b0;
        op = '0;
        data = '0;
        amount = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", {28'd0, res_valid, carry, zero, busy}, 32'd0);
        check("reset_start_ready", 32'(start_ready), 32'd1);

        vecs.push_back('{2'b00, 24'h000001, 24'd5,  24'h000020, 1'b0, 2});
        vecs.push_back('{2'b00, 24'h000001, 24'd24, 24'h000000, 1'b1, 2});
        vecs.push_back('{2'b00, 24'h000001, 24'd25, 24'h000000, 1'b0, 2});
        vecs.push_back('{2'b01, 24'h800001, 24'd1,  24'h400000, 1'b1, 2});
        vecs.push_back('{2'b10, 24'h800000, 24'd4,  24'hF80000, 1'b0, 2});
        vecs.push_back('{2'b10, 24'h800000, 24'd30, 24'hFFFFFF, 1'b1, 2});
        vecs.push_back('{2'b11, 24'h800001, 24'd1,  24'h000003, 1'b1, 3});
        vecs.push_back('{2'b11, 24'h800001, 24'd25, 24'h000003, 1'b1, 3});
        vecs.push_back('{2'b11, 24'h800001, 24'd24, 24'h800001, 1'b0, 3});
        vecs.push_back('{2'b01, 24'hABCDEF, 24'd0,  24'hABCDEF, 1'b0, 2});
        vecs.push_back('{2'b01, 24'h800000, 24'd24, 24'h000000, 1'b1, 2});
        vecs.push_back('{2'b00, 24'hFFFFFF, 24'h100000, 24'h000000, 1'b0, 2});

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].data, vecs[i].amt, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_carry", i), 32'(carry), 32'(vecs[i].exp_carry));
            check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_res == 24'd0));
            take_result();
        end

        // Backpressure: result held, start ignored while not idle.
        issue(2'b00, 24'h000011, 24'd3, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start_valid = 1'b1;
                op = 2'b01;
                data = 24'h123456;
                amount = 24'd1;
            end else begin
                start_valid = 1'b0;
            end
            check("bp_result", 32'(result), 32'h000088);
            check("bp_handshake", {29'd0, res_valid, start_ready, busy}, 32'b101);
            @(posedge clk);
            @(negedge clk);
        end
        start_valid = 1'b0;
        check("bp_result_after", 32'(result), 32'h000088);
        take_result();
        check("bp_result_idle", 32'(result), 32'h000088);

        // Reset while the ROL is in its second pass.
        @(negedge clk);
        start_valid = 1'b1;
        op = 2'b11;
        data = 24'h800001;
        amount = 24'd5;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", {30'd0, busy, res_valid}, 32'b10);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_outputs", {res_valid, carry, zero, busy, 4'd0, result}, 32'd0);
        check("rst_mid_ready", 32'(start_ready), 32'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  ro;
            logic [23:0] rd, ra;
            ro = 2'($urandom_range(0, 3));
            rd = 24'($urandom);
            case ($urandom_range(0, 3))
                0: ra = 24'($urandom_range(0, 30));
                1: ra = 24'($urandom_range(0, 60));
                2: ra = 24'($urandom);
                default: ra = 24'(24 * $urandom_range(0, 4));
            endcase
            if ($urandom_range(0, 7) == 0) rd = 24'h000000;
            ref_model(ro, rd, ra, er, ec);
            issue(ro, rd, ra, lat);
            check("rand_latency", 32'(lat), (ro == 2'b11) ? 32'd3 : 32'd2);
            check("rand_result", 32'(result), 32'(er));
            check("rand_carry", 32'(carry), 32'(ec));
            check("rand_zero", 32'(zero), 32'(er == 24'd0));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
            take_result();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
